boot_loader: RTL and testbench

Upstream program loader for the RiscCpu/SyncRam pair. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit words. It writes those words into SyncRam through the memory write port while holding the CPU in power-on init, then releases the CPU once the frame checksum is verified. While LoaderActive=1 it owns the SyncRam write port; the CPU drives the port otherwise.

---
 rtl/boot_loader.sv | 145 ++++++++++++++
 tb/tb_boot_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Framed byte-stream program loader: assembles big-endian words, writes them into
// SyncRam while holding the CPU in init, then releases it after a checksum check.
module boot_loader #(
  parameter int unsigned             WORD_WIDTH       = 16,
  parameter int unsigned             ADDR_WIDTH       = 16,
  parameter logic [ADDR_WIDTH-1:0]   LOAD_BASE        = ADDR_WIDTH'(1),
  parameter int unsigned             CPU_RESET_CYCLES = 2
) (
  input  logic                  gclk,
  input  logic                  PowerOnN,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteData,
  output logic                  ByteReady,
  output logic                  MemWriteFlag,
  output logic [ADDR_WIDTH-1:0] MemWriteAddr,
  output logic [WORD_WIDTH-1:0] MemWriteData,
  output logic                  LoaderActive,
  output logic                  CpuPowerOn,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RELEASE, RUN, ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            hi_q, hi_d;
  logic [31:0]           rel_cnt_q, rel_cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_flag_q, wr_flag_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  active_q, active_d;
  logic                  cpu_on_q, cpu_on_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    hi_d      = hi_q;
    rel_cnt_d = rel_cnt_q;
    wr_flag_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    accept    = ByteValid && ready_q;

    unique case (state_q)
      LEN_HI: if (accept) begin
        len_d[15:8] = ByteData;
        csum_d      = csum_q ^ ByteData;
        state_d     = LEN_LO;
      end
      LEN_LO: if (accept) begin
        len_d[7:0] = ByteData;
        csum_d     = csum_q ^ ByteData;
        state_d    = ({len_q[15:8], ByteData} == 16'd0) ? CHECK : DATA_HI;
      end
      DATA_HI: if (accept) begin
        hi_d    = ByteData;
        csum_d  = csum_q ^ ByteData;
        state_d = DATA_LO;
      end
      DATA_LO: if (accept) begin
        csum_d    = csum_q ^ ByteData;
        wr_flag_d = 1'b1;
        wr_addr_d = LOAD_BASE + ADDR_WIDTH'(idx_q);
        wr_data_d = WORD_WIDTH'({hi_q, ByteData});
        idx_d     = idx_q + 16'd1;
        state_d   = (idx_q == len_q - 16'd1) ? CHECK : DATA_HI;
      end
      CHECK: if (accept) begin
        rel_cnt_d = '0;
        if (ByteData != csum_q)       state_d = ERROR;
        else if (CPU_RESET_CYCLES == 0) state_d = RUN;
        else                          state_d = RELEASE;
      end
      RELEASE: begin
        // CpuPowerOn stays high for CPU_RESET_CYCLES cycles counted from entry
        if (rel_cnt_q == CPU_RESET_CYCLES - 1) state_d = RUN;
        else rel_cnt_d = rel_cnt_q + 32'd1;
      end
      RUN, ERROR: state_d = state_q;
      default:    state_d = LEN_HI;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    ready_d  = state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    active_d = !(state_d inside {RELEASE, RUN});
    cpu_on_d = (state_d != RUN);
    done_d   = (state_d == RUN);
    error_d  = (state_d == ERROR);
  end

  always_ff @(posedge gclk or negedge PowerOnN) begin
    if (!PowerOnN) begin
      state_q   <= LEN_HI;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      hi_q      <= '0;
      rel_cnt_q <= '0;
      ready_q   <= 1'b0;
      wr_flag_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      active_q  <= 1'b1;
      cpu_on_q  <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      hi_q      <= hi_d;
      rel_cnt_q <= rel_cnt_d;
      ready_q   <= ready_d;
      wr_flag_q <= wr_flag_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      active_q  <= active_d;
      cpu_on_q  <= cpu_on_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ByteReady    = ready_q;
  assign MemWriteFlag = wr_flag_q;
  assign MemWriteAddr = wr_addr_q;
  assign MemWriteData = wr_data_q;
  assign LoaderActive = active_q;
  assign CpuPowerOn   = cpu_on_q;
  assign Done         = done_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (load base 1 and FFFF) driven by the same
// frames; expectations come from a frame-level model of words, addresses and XOR.
module tb_boot_loader;

  localparam int unsigned RESET_CYC = 2;

  logic        gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        PowerOnN;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        rdy[2], wflag[2], act[2], cpu[2], done[2], err[2];
  logic [15:0] waddr[2], wdata[2];
  logic [15:0] base[2];
  logic [7:0]  fr[$];
  logic [31:0] mon0[$], mon1[$];
  int          checks = 0;
  int          failures = 0;

  boot_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .LOAD_BASE(16'h0001), .CPU_RESET_CYCLES(2)) u_dut0 (
    .gclk(gclk), .PowerOnN(PowerOnN), .ByteValid(ByteValid), .ByteData(ByteData),
    .ByteReady(rdy[0]), .MemWriteFlag(wflag[0]), .MemWriteAddr(waddr[0]), .MemWriteData(wdata[0]),
    .LoaderActive(act[0]), .CpuPowerOn(cpu[0]), .Done(done[0]), .Error(err[0]));

  boot_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .LOAD_BASE(16'hFFFF), .CPU_RESET_CYCLES(2)) u_dut1 (
    .gclk(gclk), .PowerOnN(PowerOnN), .ByteValid(ByteValid), .ByteData(ByteData),
    .ByteReady(rdy[1]), .MemWriteFlag(wflag[1]), .MemWriteAddr(waddr[1]), .MemWriteData(wdata[1]),
    .LoaderActive(act[1]), .CpuPowerOn(cpu[1]), .Done(done[1]), .Error(err[1]));

  // Record every write strobe seen, so extra or stretched pulses show up as count errors
  always @(negedge gclk) begin
    if (wflag[0] === 1'b1) mon0.push_back({waddr[0], wdata[0]});
    if (wflag[1] === 1'b1) mon1.push_back({waddr[1], wdata[1]});
  end

  initial begin
    #200000;
    $display("FAIL watchdog dut=- observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic int frame_n();
    return int'({fr[0], fr[1]});
  endfunction

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
    return x;
  endfunction

  function automatic int mon_size(input int d);
    return (d == 0) ? mon0.size() : mon1.size();
  endfunction

  function automatic logic [31:0] mon_at(input int d, input int i);
    return (d == 0) ? mon0[i] : mon1[i];
  endfunction

  // Called at a negedge; drops reset between edges and checks outputs react at once
  task automatic do_reset();
    #2;
    PowerOnN  = 1'b0;
    ByteValid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, rdy[d], 1'b0);
      chk("rst_wflag", d, wflag[d], 1'b0);
      chk("rst_waddr", d, waddr[d], 16'h0000);
      chk("rst_wdata", d, wdata[d], 16'h0000);
      chk("rst_active", d, act[d], 1'b1);
      chk("rst_cpu", d, cpu[d], 1'b1);
      chk("rst_done", d, done[d], 1'b0);
      chk("rst_error", d, err[d], 1'b0);
    end
    @(negedge gclk);
    PowerOnN = 1'b1;
    mon0.delete();
    mon1.delete();
    @(negedge gclk);
    for (int d = 0; d < 2; d++) chk("ready_after_rst", d, rdy[d], 1'b1);
  endtask

  // Offer frame byte k after `gap` idle cycles; check the write strobe the cycle after
  task automatic send_byte(input int k, input int gap);
    int waits = 0;
    int n = frame_n();
    bit exp_flag;
    int wi;
    ByteValid = 1'b0;
    repeat (gap) @(negedge gclk);
    ByteValid = 1'b1;
    ByteData  = fr[k];
    while (rdy[0] !== 1'b1 && waits < 20) begin
      @(negedge gclk);
      waits++;
    end
    chk("accept_wait", 0, (waits < 20), 1'b1);
    @(posedge gclk);
    @(negedge gclk);
    ByteValid = 1'b0;
    ByteData  = 8'($urandom);
    exp_flag  = (k >= 3) && (k <= 2 * n + 1) && (k % 2 == 1);
    wi        = (k - 3) / 2;
    for (int d = 0; d < 2; d++) begin
      chk("wflag", d, wflag[d], exp_flag);
      if (exp_flag) begin
        chk("waddr", d, waddr[d], 16'(base[d] + 16'(wi)));
        chk("wdata", d, wdata[d], {fr[k-1], fr[k]});
      end
    end
  endtask

  task automatic finish_frame();
    int  n    = frame_n();
    bit  good = (fr[fr.size()-1] == frame_xor());
    for (int d = 0; d < 2; d++) begin
      chk("end_ready", d, rdy[d], 1'b0);
      chk("end_active", d, act[d], !good);
      chk("end_cpu", d, cpu[d], 1'b1);
      chk("end_done", d, done[d], 1'b0);
      chk("end_error", d, err[d], !good);
    end
    if (good) begin
      for (int c = 1; c < RESET_CYC; c++) begin
        @(negedge gclk);
        for (int d = 0; d < 2; d++) chk("release_cpu", d, cpu[d], 1'b1);
      end
      @(negedge gclk);
      for (int d = 0; d < 2; d++) begin
        chk("run_cpu", d, cpu[d], 1'b0);
        chk("run_done", d, done[d], 1'b1);
      end
    end
    // Bytes offered in a terminal state must be ignored
    ByteValid = 1'b1;
    repeat (4) begin
      ByteData = 8'($urandom);
      @(negedge gclk);
    end
    ByteValid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("term_ready", d, rdy[d], 1'b0);
      chk("term_done", d, done[d], good);
      chk("term_error", d, err[d], !good);
      chk("term_cpu", d, cpu[d], !good);
      chk("term_active", d, act[d], !good);
      chk("write_count", d, mon_size(d), n);
      for (int i = 0; i < n && i < mon_size(d); i++)
        chk("write_log", d, mon_at(d, i),
            {16'(base[d] + 16'(i)), fr[2 + 2*i], fr[3 + 2*i]});
    end
  endtask

  task automatic run_frame(input int gap);
    for (int k = 0; k < fr.size(); k++)
      send_byte(k, (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    finish_frame();
  endtask

  task automatic build_frame(input int n, input bit bad);
    fr.delete();
    fr.push_back(8'(n >> 8));
    fr.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom));
    fr.push_back(8'h00);
    fr[fr.size()-1] = frame_xor() ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
  endtask

  initial begin
    base[0]   = 16'h0001;
    base[1]   = 16'hFFFF;
    PowerOnN  = 1'b1;
    ByteValid = 1'b0;
    ByteData  = 8'h00;
    @(negedge gclk);
    do_reset();

    fr = '{8'h00, 8'h02, 8'h00, 8'hC2, 8'h00, 8'h01, 8'hC1};
    run_frame(0);

    do_reset();
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(0);

    // XOR of 00 01 12 34 is 27, so 26 is the mismatching checksum byte
    do_reset();
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    run_frame(0);

    do_reset();
    fr = '{8'h00, 8'h02, 8'h00, 8'hC2, 8'h00, 8'h01, 8'hC1};
    run_frame(3);

    do_reset();
    for (int k = 0; k < 4; k++) send_byte(k, 0);
    do_reset();
    run_frame(0);

    do_reset();
    fr = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};
    run_frame(0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      build_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 2) == 0));
      run_frame(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
